// File: rtl/word_byte_splitter.sv
// word_byte_splitter: unpacks {hi, lo} words of 2*W bits into a stream of
// W-bit beats, high byte first, then low byte. It holds one word at a time
// and flags words whose two halves are identical.
// Optional feature macro: SPLITTER_REP_COLLAPSE_EN. When it is defined, a
// replicated word is emitted as a single low-byte beat.
module word_byte_splitter #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_byte,
  output logic             out_last,
  output logic             out_rep,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  state_t         load_state;
  logic [2*W-1:0] hold;
  logic           load;
  logic           emit_last;

`ifdef SPLITTER_REP_COLLAPSE_EN
  logic in_rep;
  assign in_rep     = (in_word[2*W-1:W] == in_word[W-1:0]);
  assign load_state = in_rep ? LO : HI;
`else
  assign load_state = HI;
`endif

  // State register; reset discards any partially emitted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, word load strobe and the input-side ready.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    emit_last  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = load_state;
        end
      end
      HI: begin
        if (out_ready) begin
          state_next = LO;
        end
      end
      LO: begin
        in_ready = out_ready;
        if (out_ready) begin
          emit_last = 1'b1;
          if (in_valid) begin
            load       = 1'b1;
            state_next = load_state;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word holding register, written only when a word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (load) begin
      hold <= in_word;
    end
  end

  // Count of words whose final beat has been accepted; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (emit_last) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Output decode from state and hold only, so outputs stay stable under stall.
  always_comb begin
    out_valid = (state != IDLE);
    out_last  = (state == LO);
    out_byte  = '0;
    out_rep   = 1'b0;
    if (state == HI) begin
      out_byte = hold[2*W-1:W];
    end else if (state == LO) begin
      out_byte = hold[W-1:0];
    end
    if (state != IDLE) begin
      out_rep = (hold[2*W-1:W] == hold[W-1:0]);
    end
  end

endmodule

// File: tb/tb_word_byte_splitter.sv
// tb_word_byte_splitter: table-driven directed vectors, hand-written corner
// sequences and randomized traffic against a queue-based beat model.
module tb_word_byte_splitter;

  localparam int W     = 8;
  localparam int CNT_W = 4;

`ifdef SPLITTER_REP_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   in_word;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_byte;
  logic             out_last;
  logic             out_rep;
  logic [CNT_W-1:0] word_cnt;

  word_byte_splitter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_rep   (out_rep),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] b;
    logic         last;
    logic         rep;
  } beat_t;

  typedef struct {
    logic [2*W-1:0] word;
    logic [W-1:0]   exp_hi;
    logic [W-1:0]   exp_lo;
    logic           exp_rep;
    int             stall_hi;
    int             stall_lo;
  } vec_t;

  beat_t exp_q[$];
  int    model_cnt;
  int    passed;
  int    total;
  vec_t  vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [2*W-1:0] word, input logic valid, input logic ready);
    in_word   = word;
    in_valid  = valid;
    out_ready = ready;
  endtask

  // Expected beats of an accepted word: hi then lo, or lo alone when collapsed.
  task automatic pushWord(input logic [2*W-1:0] w);
    beat_t bt;
    logic  rep;
    rep = (w[2*W-1:W] == w[W-1:0]);
    if (COLLAPSE && rep) begin
      bt = '{b: w[W-1:0], last: 1'b1, rep: 1'b1};
      exp_q.push_back(bt);
    end else begin
      bt = '{b: w[2*W-1:W], last: 1'b0, rep: rep};
      exp_q.push_back(bt);
      bt = '{b: w[W-1:0], last: 1'b1, rep: rep};
      exp_q.push_back(bt);
    end
  endtask

  // One clock: check outputs against the model at negedge, then advance the model.
  task automatic clockCycle();
    bit             exp_valid;
    bit             exp_ready;
    bit             in_fire;
    bit             out_fire;
    logic [2*W-1:0] w;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0);
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("out_byte", 32'(out_byte), 32'(exp_q[0].b));
      checkOutput("out_last", 32'(out_last), 32'(exp_q[0].last));
      checkOutput("out_rep", 32'(out_rep), 32'(exp_q[0].rep));
    end
    checkOutput("word_cnt", 32'(word_cnt), 32'(model_cnt % (1 << CNT_W)));
    in_fire  = in_valid && exp_ready;
    out_fire = exp_valid && out_ready;
    w        = in_word;
    @(posedge clk);
    if (out_fire) begin
      if (exp_q[0].last) model_cnt++;
      void'(exp_q.pop_front());
    end
    if (in_fire) pushWord(w);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_rep", 32'(out_rep), 32'd0);
    checkOutput("rst_out_byte", 32'(out_byte), 32'd0);
    checkOutput("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
  endtask

  // Run with out_ready high until the model has no pending beats.
  task automatic drain();
    int n;
    n = 0;
    applyStimulus('0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && n < 10) begin
      clockCycle();
      n++;
    end
    if (exp_q.size() > 0) checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int beats;
    passed    = 0;
    total     = 0;
    model_cnt = 0;

    vecs[0] = '{word: 16'hA55A, exp_hi: 8'hA5, exp_lo: 8'h5A, exp_rep: 1'b0, stall_hi: 0, stall_lo: 0};
    vecs[1] = '{word: 16'h1234, exp_hi: 8'h12, exp_lo: 8'h34, exp_rep: 1'b0, stall_hi: 0, stall_lo: 0};
    vecs[2] = '{word: 16'hBEEF, exp_hi: 8'hBE, exp_lo: 8'hEF, exp_rep: 1'b0, stall_hi: 3, stall_lo: 2};
    vecs[3] = '{word: 16'h3C3C, exp_hi: 8'h3C, exp_lo: 8'h3C, exp_rep: 1'b1, stall_hi: 0, stall_lo: 1};

    doReset();

    // Directed vectors with optional stalls on each beat.
    for (int i = 0; i < 4; i++) begin
      beats = (COLLAPSE && vecs[i].exp_rep) ? 1 : 2;
      applyStimulus(vecs[i].word, 1'b1, 1'b1);
      clockCycle();
      in_valid = 1'b0;
      if (beats == 2) begin
        for (int s = 0; s <= vecs[i].stall_hi; s++) begin
          out_ready = (s == vecs[i].stall_hi);
          #1;
          checkOutput("vec_hi_byte", 32'(out_byte), 32'(vecs[i].exp_hi));
          checkOutput("vec_hi_last", 32'(out_last), 32'd0);
          checkOutput("vec_hi_rep", 32'(out_rep), 32'(vecs[i].exp_rep));
          clockCycle();
        end
      end
      for (int s = 0; s <= vecs[i].stall_lo; s++) begin
        out_ready = (s == vecs[i].stall_lo);
        #1;
        checkOutput("vec_lo_byte", 32'(out_byte), 32'(vecs[i].exp_lo));
        checkOutput("vec_lo_last", 32'(out_last), 32'd1);
        checkOutput("vec_lo_rep", 32'(out_rep), 32'(vecs[i].exp_rep));
        clockCycle();
      end
      checkOutput("vec_idle", 32'(out_valid), 32'd0);
      checkOutput("vec_word_cnt", 32'(word_cnt), 32'(i + 1));
    end

    // Back-to-back words: second word offered early, taken during the LO beat.
    doReset();
    applyStimulus(16'h1234, 1'b1, 1'b1);
    clockCycle();
    applyStimulus(16'h5678, 1'b1, 1'b1);
    clockCycle();
    clockCycle();
    applyStimulus('0, 1'b0, 1'b1);
    #1;
    checkOutput("b2b_hi_byte", 32'(out_byte), 32'h56);
    clockCycle();
    clockCycle();
    clockCycle();
    checkOutput("b2b_word_cnt", 32'(word_cnt), 32'd2);

    // Reset asserted asynchronously while the low byte is pending.
    doReset();
    applyStimulus(16'hCAFE, 1'b1, 1'b1);
    clockCycle();
    applyStimulus('0, 1'b0, 1'b1);
    clockCycle();
    out_ready = 1'b0;
    #2;
    checkOutput("midword_in_lo", 32'(out_byte), 32'hFE);
    rst = 1'b1;
    #1;
    checkOutput("midword_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("midword_rst_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    out_ready = 1'b1;
    repeat (3) clockCycle();
    checkOutput("midword_no_fe", 32'(out_valid), 32'd0);

    // Counter wrap with a 4-bit counter.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(16'h1000 + 16'(i), 1'b1, 1'b1);
      clockCycle();
      drain();
      if (i == 14) checkOutput("wrap_15", 32'(word_cnt), 32'd15);
      if (i == 15) checkOutput("wrap_16", 32'(word_cnt), 32'd0);
      if (i == 16) checkOutput("wrap_17", 32'(word_cnt), 32'd1);
    end

    // Randomized traffic with random backpressure and some replicated words.
    doReset();
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] hb;
      logic [W-1:0] lb;
      hb = W'($urandom);
      lb = ($urandom_range(0, 3) == 0) ? hb : W'($urandom);
      applyStimulus({hb, lb}, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      clockCycle();
    end
    drain();
    checkOutput("rand_final_idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
